// File: rtl/alu_control_muldiv_if.sv
// Bundle between main control / register read and the ALU control + mul/div
// sequencer.
//
// Handshake: valid_in qualifies the decode fields and operands for the current
// cycle. There is no separate ready; stall is the back-pressure. A multu/divu
// request presented while stall=1 is not taken, and the source must hold it
// until a cycle with stall=0.
interface alu_control_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       ALUOp;
  logic [5:0]       funcfield;
  logic             valid_in;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [3:0]       ALUoperation;
  logic             md_busy;
  logic             md_done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output ALUOp, funcfield, valid_in, srcA, srcB,
    input  ALUoperation, md_busy, md_done, stall, hi, lo
  );

  modport slave (
    input  ALUOp, funcfield, valid_in, srcA, srcB,
    output ALUoperation, md_busy, md_done, stall, hi, lo
  );
endinterface

// File: rtl/alu_control_muldiv.sv
// ALU control decode plus an iterative unsigned multiply/divide sequencer that
// owns the HI/LO registers. Multiply is shift-add (LSB first), divide is
// restoring (MSB first); each takes WIDTH cycles in its working state.
module alu_control_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_control_muldiv_if.slave    bus,
  output logic [1:0]             dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor
  logic [WIDTH-1:0] whi_q;    // partial product high / partial remainder
  logic [WIDTH-1:0] wlo_q;    // multiplier shifting out / dividend->quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0] alu_op;
  logic       r_type;
  logic       md_req;
  logic       hl_use;
  logic       req_div;
  logic       last_iter;

  // Instruction decode into ALU operation, independent of sequencer state
  always_comb begin
    alu_op = 4'b1111;
    case (bus.ALUOp)
      2'b00: alu_op = 4'b0010;
      2'b01: alu_op = 4'b0110;
      2'b11: alu_op = 4'b0000;
      default: begin
        case (bus.funcfield)
          F_ADD:   alu_op = 4'b0010;
          F_SUB:   alu_op = 4'b0110;
          F_AND:   alu_op = 4'b0000;
          F_OR:    alu_op = 4'b0001;
          F_SLT:   alu_op = 4'b0111;
          F_NOR:   alu_op = 4'b1100;
          F_MULTU: alu_op = 4'b1010;
          F_DIVU:  alu_op = 4'b1010;
          F_MFHI:  alu_op = 4'b1000;
          F_MFLO:  alu_op = 4'b1001;
          default: alu_op = 4'b1111;
        endcase
      end
    endcase
  end

  assign r_type    = bus.valid_in && (bus.ALUOp == 2'b10);
  assign md_req    = r_type && ((bus.funcfield == F_MULTU) || (bus.funcfield == F_DIVU));
  assign hl_use    = md_req || (r_type && ((bus.funcfield == F_MFHI) || (bus.funcfield == F_MFLO)));
  assign req_div   = (bus.funcfield == F_DIVU);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    mul_sum   = {1'b0, whi_q} + (wlo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], wlo_q[WIDTH-1:1]};
    div_shift = {whi_q, wlo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_hi_n  = div_shift[WIDTH-1:0];
    div_lo_n  = {wlo_q[WIDTH-2:0], 1'b0};
    if (!div_diff[WIDTH+1]) begin
      // Remainder fits in WIDTH bits whenever the trial subtract succeeds
      div_hi_n = div_diff[WIDTH-1:0];
      div_lo_n = {wlo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sequencer FSM with registered busy/done and HI/LO write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      whi_q   <= '0;
      wlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (md_req) begin
            opnd_q  <= req_div ? bus.srcB : bus.srcA;
            wlo_q   <= req_div ? bus.srcA : bus.srcB;
            whi_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= req_div ? S_DIV : S_MUL;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_MUL: begin
          whi_q <= mul_hi_n;
          wlo_q <= mul_lo_n;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi_q    <= mul_hi_n;
            lo_q    <= mul_lo_n;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DIV: begin
          whi_q <= div_hi_n;
          wlo_q <= div_lo_n;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi_q    <= div_hi_n;
            lo_q    <= div_lo_n;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ALUoperation = alu_op;
  assign bus.md_busy      = busy_q;
  assign bus.md_done      = done_q;
  assign bus.stall        = hl_use && ((state_q == S_MUL) || (state_q == S_DIV));
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Bench for alu_control_muldiv at WIDTH=8: decode table, fixed-latency
// multiply/divide runs against an arithmetic reference, stall / back-to-back
// sequences, reset mid-operation and the valid_in=0 case.
module tb_alu_control_muldiv;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  // Clock generation
  always #5 clk = ~clk;

  alu_control_muldiv_if #(.WIDTH(W)) bus ();

  alu_control_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   cur_hi;
  logic [W-1:0]   cur_lo;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } dec_t;
  dec_t dec_tab[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, result packed as {hi, lo}
  function automatic logic [2*W-1:0] model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (!is_div)      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    else if (b == 0)  p = {a, {W{1'b1}}};
    else              p = {a % b, a / b};
    return p;
  endfunction

  function automatic logic [3:0] dec_model(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (op == 2'd3) return 4'b0000;
    case (fn)
      6'h20: return 4'b0010;
      6'h22: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25: return 4'b0001;
      6'h2A: return 4'b0111;
      6'h27: return 4'b1100;
      6'h19, 6'h1B: return 4'b1010;
      6'h10: return 4'b1000;
      6'h12: return 4'b1001;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.valid_in  = 1'b0;
    bus.ALUOp     = 2'd0;
    bus.funcfield = 6'd0;
  endtask

  task automatic drive_req(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ALUOp     = 2'd2;
    bus.funcfield = is_div ? 6'h1B : 6'h19;
    bus.valid_in  = 1'b1;
    bus.srcA      = a;
    bus.srcB      = b;
  endtask

  // One request with exact latency checks; operands scrambled after acceptance
  task automatic run_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    drive_req(is_div, a, b);
    exp_q.push_back(model(is_div, a, b));
    step();
    bus.valid_in = 1'b0;
    bus.srcA     = W'($urandom);
    bus.srcB     = W'($urandom);
    for (int k = 1; k <= W; k++) begin
      chk("busy", {63'd0, bus.md_busy}, 64'd1);
      chk("done_early", {63'd0, bus.md_done}, 64'd0);
      chk("hilo_hold", {48'd0, bus.hi, bus.lo}, {48'd0, cur_hi, cur_lo});
      step();
    end
    e = exp_q.pop_front();
    chk("done", {63'd0, bus.md_done}, 64'd1);
    chk("busy_end", {63'd0, bus.md_busy}, 64'd0);
    chk("result", {48'd0, bus.hi, bus.lo}, {48'd0, e});
    cur_hi = e[2*W-1:W];
    cur_lo = e[W-1:0];
    step();
    chk("done_pulse", {63'd0, bus.md_done}, 64'd0);
    idle_in();
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2*W-1:0] e;
    int dcount;
    dec_tab[0]  = '{2'd0, 6'h20, 4'b0010};
    dec_tab[1]  = '{2'd1, 6'h2A, 4'b0110};
    dec_tab[2]  = '{2'd3, 6'h19, 4'b0000};
    dec_tab[3]  = '{2'd2, 6'h20, 4'b0010};
    dec_tab[4]  = '{2'd2, 6'h22, 4'b0110};
    dec_tab[5]  = '{2'd2, 6'h24, 4'b0000};
    dec_tab[6]  = '{2'd2, 6'h25, 4'b0001};
    dec_tab[7]  = '{2'd2, 6'h2A, 4'b0111};
    dec_tab[8]  = '{2'd2, 6'h27, 4'b1100};
    dec_tab[9]  = '{2'd2, 6'h0A, 4'b1111};
    dec_tab[10] = '{2'd2, 6'h19, 4'b1010};
    dec_tab[11] = '{2'd2, 6'h1B, 4'b1010};
    dec_tab[12] = '{2'd2, 6'h10, 4'b1000};
    dec_tab[13] = '{2'd2, 6'h12, 4'b1001};

    // Reset block
    rst = 1'b1;
    idle_in();
    bus.srcA = '0;
    bus.srcB = '0;
    cur_hi = '0;
    cur_lo = '0;
    step();
    step();
    chk("rst_busy", {63'd0, bus.md_busy}, 64'd0);
    chk("rst_done", {63'd0, bus.md_done}, 64'd0);
    chk("rst_hilo", {48'd0, bus.hi, bus.lo}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b0;
    step();

    // Decode table (valid_in low so nothing starts)
    for (int i = 0; i < 14; i++) begin
      bus.ALUOp     = dec_tab[i].op;
      bus.funcfield = dec_tab[i].fn;
      #1;
      chk("decode_tab", {60'd0, bus.ALUoperation}, {60'd0, dec_tab[i].exp});
      chk("decode_nostall", {63'd0, bus.stall}, 64'd0);
    end
    for (int i = 0; i < 40; i++) begin
      bus.ALUOp     = 2'($urandom_range(0, 3));
      bus.funcfield = 6'($urandom);
      #1;
      chk("decode_rand", {60'd0, bus.ALUoperation}, {60'd0, dec_model(bus.ALUOp, bus.funcfield)});
    end
    idle_in();
    step();

    // Directed corner values
    run_op(1'b0, 8'hFF, 8'h02);
    chk("mul_ff_x2", {48'd0, bus.hi, bus.lo}, 64'h01FE);
    run_op(1'b1, 8'd100, 8'd7);
    chk("div_100_7", {48'd0, bus.hi, bus.lo}, {48'd0, 8'd2, 8'd14});
    run_op(1'b1, 8'd5, 8'd0);
    chk("div_by_zero", {48'd0, bus.hi, bus.lo}, {48'd0, 8'd5, 8'hFF});
    run_op(1'b0, 8'hFF, 8'hFF);
    chk("mul_max", {48'd0, bus.hi, bus.lo}, 64'hFE01);

    // Randomized operations against the reference
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(1'($urandom_range(0, 1)), ra, rb);
    end

    // mflo issued 3 cycles into multu: stalls until DONE
    drive_req(1'b0, 8'h0F, 8'h03);
    exp_q.push_back(model(1'b0, 8'h0F, 8'h03));
    step();
    idle_in();
    step();
    step();
    bus.ALUOp     = 2'd2;
    bus.funcfield = 6'h12;
    bus.valid_in  = 1'b1;
    #1;
    for (int k = 3; k <= W; k++) begin
      chk("mflo_stall", {63'd0, bus.stall}, 64'd1);
      chk("mflo_aluop", {60'd0, bus.ALUoperation}, 64'b1001);
      step();
    end
    e = exp_q.pop_front();
    chk("mflo_done_nostall", {63'd0, bus.stall}, 64'd0);
    chk("mflo_done", {63'd0, bus.md_done}, 64'd1);
    chk("mflo_result", {48'd0, bus.hi, bus.lo}, {48'd0, e});
    cur_hi = e[2*W-1:W];
    cur_lo = e[W-1:0];
    step();
    chk("mflo_after", {63'd0, bus.stall}, 64'd0);
    idle_in();
    step();

    // Second multu held valid during busy, accepted in DONE
    drive_req(1'b0, 8'h21, 8'h05);
    exp_q.push_back(model(1'b0, 8'h21, 8'h05));
    step();
    drive_req(1'b0, 8'hC3, 8'h7E);
    exp_q.push_back(model(1'b0, 8'hC3, 8'h7E));
    #1;
    for (int k = 1; k <= W; k++) begin
      chk("b2b_stall", {63'd0, bus.stall}, 64'd1);
      step();
    end
    e = exp_q.pop_front();
    chk("b2b_first_done", {63'd0, bus.md_done}, 64'd1);
    chk("b2b_first_nostall", {63'd0, bus.stall}, 64'd0);
    chk("b2b_first_result", {48'd0, bus.hi, bus.lo}, {48'd0, e});
    step();
    idle_in();
    bus.srcA = W'($urandom);
    for (int k = 1; k <= W; k++) begin
      chk("b2b_second_busy", {63'd0, bus.md_busy}, 64'd1);
      step();
    end
    e = exp_q.pop_front();
    chk("b2b_second_done", {63'd0, bus.md_done}, 64'd1);
    chk("b2b_second_result", {48'd0, bus.hi, bus.lo}, {48'd0, e});
    cur_hi = e[2*W-1:W];
    cur_lo = e[W-1:0];
    step();

    // Reset mid-divide: everything cleared, no late md_done
    drive_req(1'b1, 8'd200, 8'd3);
    step();
    idle_in();
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", {63'd0, bus.md_busy}, 64'd0);
    chk("midrst_done", {63'd0, bus.md_done}, 64'd0);
    chk("midrst_hilo", {48'd0, bus.hi, bus.lo}, 64'd0);
    cur_hi = '0;
    cur_lo = '0;
    dcount = 0;
    for (int k = 0; k < 2 * W; k++) begin
      step();
      if (bus.md_done) dcount++;
    end
    chk("midrst_no_done", 64'(dcount), 64'd0);

    // Seed known hi/lo, then multu with valid_in=0 must do nothing
    run_op(1'b0, 8'h12, 8'h34);
    bus.ALUOp     = 2'd2;
    bus.funcfield = 6'h19;
    bus.valid_in  = 1'b0;
    bus.srcA      = 8'hAA;
    bus.srcB      = 8'h55;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("novalid_stall", {63'd0, bus.stall}, 64'd0);
      chk("novalid_aluop", {60'd0, bus.ALUoperation}, 64'b1010);
      step();
      chk("novalid_busy", {63'd0, bus.md_busy}, 64'd0);
      chk("novalid_hilo", {48'd0, bus.hi, bus.lo}, {48'd0, cur_hi, cur_lo});
    end
    idle_in();
    step();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
